// File: rtl/cpu_program_memory.sv
// ---------------------------------------------------------------------------
// cpu_program_memory
//   Program/data memory that sits on the CPU memory port. It includes a
//   byte-stream loader that fills the whole array from a valid/ready source.
//   The loader keeps the CPU in clear until the whole image has been written,
//   and only then releases it.
//
//   Optional build macro: LOAD_CHECKSUM_EN. When it is defined, the module
//   adds a load_sum output. load_sum is a modulo-2**DATA_W sum of the bytes
//   accepted during the current load.
//
// Ports
//   clk, clr_n      clock; asynchronous active-low reset
//   read, write     CPU strobes (only honoured in RUN)
//   address         CPU word address
//   memoryIn        CPU write data
//   memoryOut       CPU read data. Combinational; it is 0 unless RUN & read.
//   load_start      one-cycle request to start loading an image
//   load_valid      loader byte valid
//   load_data       loader byte
//   load_ready      memory accepts a loader byte this cycle
//   load_done       one-cycle pulse, high in the first cycle of RUN
//   cpu_clr         CPU clear; high while no complete image is present
//   load_sum        (LOAD_CHECKSUM_EN only) running sum of the loaded bytes
// ---------------------------------------------------------------------------
module cpu_program_memory #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] memoryIn,
    output logic [DATA_W-1:0] memoryOut,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              load_done,
`ifdef LOAD_CHECKSUM_EN
    output logic [DATA_W-1:0] load_sum,
`endif
    output logic              cpu_clr
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {BOOT, LOAD, FLUSH, RUN} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_cpu_clr;
    logic              r_load_ready;
    logic              r_load_done;
    logic [DATA_W-1:0] r_sum;

    // r_load_ready is high only in LOAD, so a byte is accepted whenever
    // load_valid is high in that state.
    logic w_accept;
    assign w_accept = r_load_ready && load_valid;

    // The read is zero-latency. A same-cycle write lands only at the edge,
    // so a read in that cycle returns the old contents.
    assign memoryOut  = (r_state == RUN && read) ? r_mem[address] : '0;
    assign cpu_clr    = r_cpu_clr;
    assign load_ready = r_load_ready;
    assign load_done  = r_load_done;
`ifdef LOAD_CHECKSUM_EN
    assign load_sum   = r_sum;
`endif

    // The outputs are registered. Each one is written together with the
    // state transition that changes it, so it lines up with the new state.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state      <= BOOT;
            r_cnt        <= '0;
            r_cpu_clr    <= 1'b1;
            r_load_ready <= 1'b0;
            r_load_done  <= 1'b0;
            r_sum        <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_load_done <= 1'b0;
            case (r_state)
                BOOT: begin
                    if (load_start) begin
                        r_state      <= LOAD;
                        r_cnt        <= '0;
                        r_sum        <= '0;
                        r_load_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        r_mem[r_cnt] <= load_data;
                        r_cnt        <= r_cnt + 1'b1;   // wraps to 0 after the last word
                        r_sum        <= r_sum + load_data;
                        if (&r_cnt) begin
                            r_state      <= FLUSH;
                            r_load_ready <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    r_state     <= RUN;
                    r_cpu_clr   <= 1'b0;
                    r_load_done <= 1'b1;
                end
                RUN: begin
                    // The CPU write is still honoured in the cycle that
                    // load_start re-enters LOAD.
                    if (write) r_mem[address] <= memoryIn;
                    if (load_start) begin
                        r_state      <= LOAD;
                        r_cnt        <= '0;
                        r_sum        <= '0;
                        r_cpu_clr    <= 1'b1;
                        r_load_ready <= 1'b1;
                    end
                end
                default: r_state <= BOOT;
            endcase
        end
    end

`ifndef LOAD_CHECKSUM_EN
    // The sum register is only observable through the optional port. The
    // synthesis tool trims it when that port is absent.
    logic w_unused_sum;
    assign w_unused_sum = ^r_sum;
`endif

endmodule

// File: tb/tb_cpu_program_memory.sv
module tb_cpu_program_memory;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       read, write;
    logic [3:0] address;
    logic [7:0] memoryIn, memoryOut;
    logic       load_start, load_valid, load_ready, load_done, cpu_clr;
    logic [7:0] load_data;
`ifdef LOAD_CHECKSUM_EN
    logic [7:0] load_sum;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] model [16];
    logic [7:0] sb [$];

    cpu_program_memory #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .read       (read),
        .write      (write),
        .address    (address),
        .memoryIn   (memoryIn),
        .memoryOut  (memoryOut),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .load_done  (load_done),
`ifdef LOAD_CHECKSUM_EN
        .load_sum   (load_sum),
`endif
        .cpu_clr    (cpu_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The expected value is queued when the read is driven, then popped and
    // compared against memoryOut in the middle of the same cycle.
    task automatic rd(input logic [3:0] a);
        read    = 1'b1;
        address = a;
        sb.push_back(model[a]);
        @(negedge clk);
        chk("rd", memoryOut, sb.pop_front());
        tick();
        read = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    // Loads a full image. Byte i is start + i*step. When gap is set, valid is
    // dropped for two cycles after byte 5.
    task automatic load_img(input logic [7:0] start, input logic [7:0] step, input bit gap);
        for (int i = 0; i < 16; i++) begin
            load_valid = 1'b1;
            load_data  = start + 8'(i) * step;
            @(negedge clk);
            chk("load_ready", 8'(load_ready), 8'd1);
            chk("cpu_clr_load", 8'(cpu_clr), 8'd1);
            tick();
            model[i] = start + 8'(i) * step;
            if (gap && i == 5) begin
                load_valid = 1'b0;
                load_data  = 8'hEE;
                repeat (2) begin
                    @(negedge clk);
                    chk("ready_gap", 8'(load_ready), 8'd1);
                    tick();
                end
            end
        end
        load_valid = 1'b0;
        @(negedge clk);
        chk("flush_clr", 8'(cpu_clr), 8'd1);
        chk("flush_ready", 8'(load_ready), 8'd0);
        chk("flush_done", 8'(load_done), 8'd0);
        tick();
        chk("run_clr", 8'(cpu_clr), 8'd0);
        chk("run_done", 8'(load_done), 8'd1);
        tick();
        chk("done_once", 8'(load_done), 8'd0);
        chk("run_clr2", 8'(cpu_clr), 8'd0);
    endtask

    initial begin
        clr_n = 1'b0; read = 1'b0; write = 1'b0; address = '0; memoryIn = '0;
        load_start = 1'b0; load_valid = 1'b0; load_data = '0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        repeat (2) tick();
        clr_n = 1'b1;

        // Idle in BOOT: CPU reads are masked.
        read = 1'b1; address = 4'd3;
        repeat (5) tick();
        @(negedge clk);
        chk("boot_clr", 8'(cpu_clr), 8'd1);
        chk("boot_ready", 8'(load_ready), 8'd0);
        chk("boot_rdata", memoryOut, 8'h00);
        chk("boot_done", 8'(load_done), 8'd0);
        tick();
        read = 1'b0;

        // Load the image with a valid gap, then read it back.
        pulse_start();
        load_img(8'h10, 8'h01, 1'b1);
        for (int i = 0; i < 16; i++) rd(4'(i));
        address = 4'd4; read = 1'b0;
        @(negedge clk);
        chk("rd_off", memoryOut, 8'h00);
        tick();

        // Write and read in the same cycle: the read returns pre-edge data.
        write = 1'b1; read = 1'b1; address = 4'd9; memoryIn = 8'hA5;
        sb.push_back(model[9]);
        @(negedge clk);
        chk("rd_during_wr", memoryOut, sb.pop_front());
        tick();
        write = 1'b0; read = 1'b0;
        model[9] = 8'hA5;
        rd(4'd9);
        rd(4'd8);

        // Reload from RUN, then reset partway through the load.
        pulse_start();
        @(negedge clk);
        chk("reload_clr", 8'(cpu_clr), 8'd1);
        chk("reload_ready", 8'(load_ready), 8'd1);
        for (int i = 0; i < 7; i++) begin
            load_valid = 1'b1;
            load_data  = 8'h60 + 8'(i);
            tick();
        end
        load_valid = 1'b0;
        #2 clr_n = 1'b0;
        #1;
        chk("rst_clr", 8'(cpu_clr), 8'd1);
        chk("rst_ready", 8'(load_ready), 8'd0);
        for (int i = 0; i < 16; i++) begin
            chk("rst_mem", dut.r_mem[i], 8'h00);
            model[i] = 8'h00;
        end
        tick();
        clr_n = 1'b1;
        read = 1'b1; address = 4'd3;
        @(negedge clk);
        chk("rst_rdata", memoryOut, 8'h00);
        tick();
        read = 1'b0;

        // Recover with a fresh full load.
        pulse_start();
        load_img(8'hF0, 8'h00, 1'b0);
`ifdef LOAD_CHECKSUM_EN
        chk("sum_f0", load_sum, 8'h00);
`endif
        rd(4'd0);
        rd(4'd15);
        pulse_start();
`ifdef LOAD_CHECKSUM_EN
        chk("sum_clear", load_sum, 8'h00);
`endif
        load_img(8'h01, 8'h01, 1'b0);
`ifdef LOAD_CHECKSUM_EN
        chk("sum_01_10", load_sum, 8'h88);
        tick();
        chk("sum_hold", load_sum, 8'h88);
`endif
        rd(4'd7);
        rd(4'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_program_memory.md
Name: cpu_program_memory

Overview:
- Program/data memory directly downstream of the CPU's memory port. Consumes `read`, `write`, `address` and `memoryIn`; produces `memoryOut`.
- Contains a byte-stream loader that fills the memory from an external valid/ready source.
- Holds the CPU in clear (`cpu_clr`) until a complete image has been written, then releases it.

Parameters:
- ADDR_W, 4, address width; depth = 2**ADDR_W words.
- DATA_W, 8, word width; must match the CPU bus.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr_n  input  1  asynchronous active-low reset.
- read  input  1  CPU read strobe.
- write  input  1  CPU write strobe.
- address  input  ADDR_W  CPU address (CPU AR).
- memoryIn  input  DATA_W  CPU write data (CPU bus).
- memoryOut  output  DATA_W  read data to CPU.
- load_start  input  1  one-cycle request to begin loading an image.
- load_valid  input  1  loader byte valid.
- load_data  input  DATA_W  loader byte.
- load_ready  output  1  memory accepts a loader byte this cycle.
- load_done  output  1  one-cycle pulse when the CPU is released.
- cpu_clr  output  1  drives the CPU `clr`; high holds the CPU in clear.

Behaviour:
- Reset (clr_n low, asynchronous):
  - every memory word = 0; state = BOOT; load address counter = 0.
  - cpu_clr = 1, load_ready = 0, load_done = 0, memoryOut = 0.
- States: BOOT, LOAD, FLUSH, RUN.
- BOOT:
  - cpu_clr = 1; load_ready = 0; CPU read/write ignored; memoryOut = 0.
  - load_start -> LOAD, with counter = 0.
- LOAD:
  - cpu_clr = 1; load_ready = 1.
  - On load_valid & load_ready: mem[counter] <= load_data and counter increments.
  - load_valid low: no write; the counter holds.
  - Accepting the byte at counter = DEPTH-1 -> FLUSH; counter wraps to 0.
  - load_start is ignored in LOAD. CPU strobes are ignored; memoryOut = 0.
- FLUSH (exactly 1 cycle):
  - cpu_clr = 1; load_ready = 0; next state RUN.
  - load_done = 1 for that one cycle, registered so it coincides with the first RUN cycle.
- RUN:
  - cpu_clr = 0.
  - memoryOut = mem[address] combinationally when read = 1, else 0. Zero-latency read: the CPU samples data in the same cycle it asserts read.
  - write = 1: mem[address] <= memoryIn at the rising edge.
  - read and write both high: the write is performed; memoryOut shows pre-edge contents.
  - Read of an address written this cycle returns the old value until the edge.
  - load_start -> LOAD: counter = 0 and cpu_clr rises the next cycle. CPU write in that same cycle is still performed.
- Reset mid-LOAD: returns to BOOT. Memory is cleared and the partial image is discarded.
- Counter is ADDR_W bits and wraps naturally.

Optional Feature:
- Macro: LOAD_CHECKSUM_EN.
- Defined:
  - adds output port load_sum [DATA_W-1:0].
  - load_sum is an 8-bit modulo-256 sum of all bytes accepted in the current LOAD.
  - It clears to 0 on reset and on LOAD entry, and holds its value after FLUSH.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, idle 5 cycles -> cpu_clr = 1, load_ready = 0, memoryOut = 0 even with read = 1 and address = 3.
- load_start, then 16 bytes 0x10..0x1F with load_valid dropped for 2 cycles after byte 5 -> mem[i] = 0x10+i. After the last byte, one FLUSH cycle, then cpu_clr = 0 with load_done high for exactly one cycle. The counter does not advance during the gap.
- RUN, address = 4, read = 1 -> memoryOut = 0x14 in the same cycle. read = 0 -> memoryOut = 0.
- RUN, write = 1, address = 9, memoryIn = 0xA5, read = 1 in the same cycle -> memoryOut = 0x19 that cycle. Subsequent read returns 0xA5.
- RUN, pulse load_start -> cpu_clr = 1 next cycle and load_ready = 1. Assert clr_n low after 7 accepted bytes -> state BOOT, mem[0..15] = 0, cpu_clr = 1.
- With LOAD_CHECKSUM_EN, load bytes 0xF0 x16 -> load_sum = 0x00. Load bytes 0x01..0x10 -> load_sum = 0x88.
